// File: rtl/weapon_fire_scheduler.sv
// Fire-control scheduler: round-robin arbitration of weapon stations onto
// the shared magazine counter, with ammo/mode gating, reloads and cooldown.
module weapon_fire_scheduler #(
  parameter int N_REQ = 4,
  parameter int W     = 9,
  parameter int CD_W  = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [3:0]         mode_selector,
  input  logic [N_REQ-1:0]   fire_req,
  input  logic [N_REQ*W-1:0] rate_tbl,
  input  logic               reload_req,
  input  logic [W-1:0]       reload_amount,
  input  logic [W-1:0]       ammo_level,
  input  logic [CD_W-1:0]    cooldown,
  output logic               ctr_load,
  output logic [W-1:0]       ctr_in,
  output logic               ctr_down,
  output logic [W-1:0]       ctr_rate,
  output logic [N_REQ-1:0]   grant,
  output logic               busy,
  output logic               error,
  output logic [1:0]         err_code
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [3:0] ATTACK = 4'b0010;

  typedef enum logic [1:0] {
    IDLE,
    FIRE,
    COOLDOWN,
    RELOAD
  } state_t;

  state_t          state_q;
  logic [PW-1:0]   ptr_q;
  logic [PW-1:0]   win_q;
  logic [W-1:0]    rate_q;
  logic [CD_W-1:0] cnt_q;
  logic            err_q;
  logic [1:0]      code_q;

  logic [PW-1:0]   win_d;
  logic [W-1:0]    rate_d;
  logic            found;
  int              idx;

  // Rotating search starting just past the last winner
  always_comb begin
    win_d = ptr_q;
    found = 1'b0;
    idx   = 0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = (int'(ptr_q) + k) % N_REQ;
      if (!found && fire_req[idx]) begin
        win_d = PW'(idx);
        found = 1'b1;
      end
    end
    rate_d = rate_tbl[int'(win_d)*W +: W];
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      ptr_q   <= PW'(N_REQ - 1);
      win_q   <= '0;
      rate_q  <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      code_q  <= 2'b00;
    end else begin
      err_q  <= 1'b0;
      code_q <= 2'b00;
      unique case (state_q)
        IDLE: begin
          if (reload_req) begin
            state_q <= RELOAD;
          end else if (|fire_req) begin
            if (mode_selector != ATTACK) begin
              err_q  <= 1'b1;
              code_q <= 2'b01;
            end else begin
              ptr_q <= win_d;
              if (rate_d == '0) begin
                err_q  <= 1'b1;
                code_q <= 2'b11;
              end else if (ammo_level < rate_d) begin
                err_q  <= 1'b1;
                code_q <= 2'b10;
              end else begin
                win_q   <= win_d;
                rate_q  <= rate_d;
                state_q <= FIRE;
              end
            end
          end
        end
        FIRE: begin
          if (cooldown != '0) begin
            cnt_q   <= cooldown;
            state_q <= COOLDOWN;
          end else begin
            state_q <= IDLE;
          end
        end
        COOLDOWN: begin
          if (reload_req) begin
            cnt_q   <= '0;
            state_q <= RELOAD;
          end else if (cnt_q <= CD_W'(1)) begin
            cnt_q   <= '0;
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        RELOAD: begin
          if (!reload_req) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    grant = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (state_q == FIRE && win_q == PW'(i)) grant[i] = 1'b1;
    end
    ctr_down = (state_q == FIRE);
    ctr_rate = (state_q == FIRE) ? rate_q : '0;
    ctr_load = (state_q == RELOAD);
    ctr_in   = (state_q == RELOAD) ? reload_amount : '0;
    busy     = (state_q != IDLE);
    error    = err_q;
    err_code = code_q;
  end

endmodule

// File: tb/tb_weapon_fire_scheduler.sv
// Directed bench for weapon_fire_scheduler with a shot scoreboard.
module tb_weapon_fire_scheduler;

  localparam int N_REQ = 4;
  localparam int W     = 9;
  localparam int CD_W  = 4;

  logic               clk = 1'b0;
  logic               rst;
  logic [3:0]         mode_selector;
  logic [N_REQ-1:0]   fire_req;
  logic [N_REQ*W-1:0] rate_tbl;
  logic               reload_req;
  logic [W-1:0]       reload_amount;
  logic [W-1:0]       ammo_level;
  logic [CD_W-1:0]    cooldown;
  logic               ctr_load;
  logic [W-1:0]       ctr_in;
  logic               ctr_down;
  logic [W-1:0]       ctr_rate;
  logic [N_REQ-1:0]   grant;
  logic               busy;
  logic               error;
  logic [1:0]         err_code;

  weapon_fire_scheduler #(.N_REQ(N_REQ), .W(W), .CD_W(CD_W)) dut (
    .clk(clk), .rst(rst), .mode_selector(mode_selector),
    .fire_req(fire_req), .rate_tbl(rate_tbl), .reload_req(reload_req),
    .reload_amount(reload_amount), .ammo_level(ammo_level),
    .cooldown(cooldown), .ctr_load(ctr_load), .ctr_in(ctr_in),
    .ctr_down(ctr_down), .ctr_rate(ctr_rate), .grant(grant),
    .busy(busy), .error(error), .err_code(err_code)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N_REQ-1:0] g;
    logic [W-1:0]     r;
  } shot_t;

  shot_t q[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_shot = 0;
  int prev_shot = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst) chk("load_down_excl", 64'(ctr_load & ctr_down), 64'd0);
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic push(input logic [N_REQ-1:0] g, input logic [W-1:0] r);
    shot_t s;
    s.g = g;
    s.r = r;
    q.push_back(s);
  endtask

  task automatic wait_shot(input string tag);
    int n;
    bit got;
    shot_t e;
    n = 0;
    got = 0;
    while (!got && n < 12) begin
      step();
      n++;
      if (ctr_down) got = 1;
    end
    chk({tag, "_seen"}, 64'(got), 64'd1);
    if (got && q.size() > 0) begin
      e = q.pop_front();
      chk({tag, "_grant"}, 64'(grant), 64'(e.g));
      chk({tag, "_rate"}, 64'(ctr_rate), 64'(e.r));
      prev_shot = last_shot;
      last_shot = cyc;
    end
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy && n < 12) begin
      step();
      n++;
    end
    chk({tag, "_idle"}, 64'(busy), 64'd0);
  endtask

  function automatic logic [63:0] all_outs();
    return 64'({ctr_load, ctr_in, ctr_down, ctr_rate, grant,
                busy, error, err_code});
  endfunction

  initial begin
    rst           = 1'b0;
    mode_selector = 4'b0010;
    fire_req      = 4'b1111;
    rate_tbl      = {4{9'd5}};
    reload_req    = 1'b1;
    reload_amount = 9'd200;
    ammo_level    = 9'd500;
    cooldown      = 4'd2;

    // reset held with requests active
    repeat (3) step();
    chk("reset_outs", all_outs(), 64'd0);
    rst        = 1'b1;
    reload_req = 1'b0;
    push(4'b0001, 9'd5);
    wait_shot("first_after_reset");
    fire_req = '0;
    wait_idle("post_first");

    // round robin from a fresh pointer
    rst = 1'b0;
    step();
    rst      = 1'b1;
    fire_req = 4'b1011;
    push(4'b0001, 9'd5);
    push(4'b0010, 9'd5);
    push(4'b1000, 9'd5);
    push(4'b0001, 9'd5);
    wait_shot("rr0");
    wait_shot("rr1");
    chk("rr_space1", 64'(last_shot - prev_shot), 64'd4);
    wait_shot("rr2");
    chk("rr_space2", 64'(last_shot - prev_shot), 64'd4);
    wait_shot("rr3");
    chk("rr_space3", 64'(last_shot - prev_shot), 64'd4);
    fire_req = '0;
    wait_idle("post_rr");

    // not attack mode
    mode_selector = 4'b0001;
    fire_req      = 4'b0001;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("nomode_err", 64'({error, err_code}), 64'({1'b1, 2'b01}));
      chk("nomode_down", 64'(ctr_down), 64'd0);
    end
    fire_req      = '0;
    mode_selector = 4'b0010;
    step();
    chk("nomode_clear", 64'(error), 64'd0);

    // insufficient ammo, then exactly enough
    ammo_level = 9'd3;
    fire_req   = 4'b0001;
    for (int i = 0; i < 2; i++) begin
      step();
      chk("ammo_err", 64'({error, err_code}), 64'({1'b1, 2'b10}));
      chk("ammo_down", 64'(ctr_down), 64'd0);
    end
    ammo_level = 9'd5;
    push(4'b0001, 9'd5);
    wait_shot("ammo_exact");
    chk("ammo_exact_noerr", 64'(error), 64'd0);
    fire_req = '0;
    wait_idle("post_ammo");
    ammo_level = 9'd500;

    // zero rate on station 2
    rate_tbl[2*W +: W] = '0;
    fire_req = 4'b0100;
    step();
    chk("zero_rate_err", 64'({error, err_code}), 64'({1'b1, 2'b11}));
    chk("zero_rate_down", 64'(ctr_down), 64'd0);
    fire_req = '0;
    rate_tbl = {4{9'd5}};
    step();

    // reload beats fire in the same idle cycle
    reload_req = 1'b1;
    fire_req   = 4'b0001;
    step();
    chk("rl_load", 64'({ctr_load, ctr_in}), 64'({1'b1, 9'd200}));
    chk("rl_nodown_noerr", 64'({ctr_down, error}), 64'd0);
    chk("rl_busy", 64'(busy), 64'd1);
    reload_amount = 9'd123;
    step();
    chk("rl_live_in", 64'(ctr_in), 64'd123);
    reload_req = 1'b0;
    fire_req   = '0;
    step();
    chk("rl_exit", 64'({ctr_load, ctr_in, busy}), 64'd0);

    // reload aborts cooldown
    fire_req = 4'b0001;
    push(4'b0001, 9'd5);
    wait_shot("cd_shot");
    fire_req = '0;
    step();
    chk("cd_state", 64'({busy, ctr_load, ctr_down}), 64'({1'b1, 2'b00}));
    reload_req = 1'b1;
    step();
    chk("cd_abort_load", 64'({ctr_load, ctr_in}), 64'({1'b1, 9'd123}));
    reload_req = 1'b0;
    step();
    step();
    chk("cd_abort_idle", 64'(busy), 64'd0);

    // reset during FIRE restores the pointer
    fire_req = 4'b0010;
    push(4'b0010, 9'd5);
    wait_shot("pre_rst_fire");
    rst      = 1'b0;
    fire_req = 4'b1111;
    step();
    chk("rst_fire_outs", all_outs(), 64'd0);
    rst = 1'b1;
    push(4'b0001, 9'd5);
    wait_shot("after_rst_fire");
    fire_req = '0;
    wait_idle("post_rst_fire");

    // reset during RELOAD
    reload_req = 1'b1;
    step();
    chk("pre_rst_rl", 64'(ctr_load), 64'd1);
    rst = 1'b0;
    step();
    chk("rst_rl_outs", all_outs(), 64'd0);
    rst        = 1'b1;
    reload_req = 1'b0;
    fire_req   = 4'b1111;
    push(4'b0001, 9'd5);
    wait_shot("after_rst_rl");
    fire_req = '0;
    wait_idle("final");
    chk("scoreboard_empty", 64'(q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
